ring_sequence_checker: RTL and testbench

//   Receive-side partner of the one-hot ring counter. Samples a one-hot ring bus
//   and checks that exactly one bit is set and that the set bit advances by one

---
 rtl/ring_sequence_checker.sv | 169 ++++++++++++++++
 tb/tb_ring_sequence_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_sequence_checker.sv
// Receive-side health monitor for a one-hot ring bus: checks one-hot legality and
// single-step rotation, decodes the hot bit, tracks lock and counts errors.
module ring_sequence_checker #(
    parameter int unsigned N         = 4,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 en,
    input  logic [N-1:0]         ring_in,
    input  logic                 clr_err,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid,
    output logic                 locked,
    output logic                 err_onehot,
    output logic                 err_seq,
    output logic [7:0]           err_cnt
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = $clog2(N + 1);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(ERR_LIMIT + 1);

    localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_CNT);
    localparam logic [BW-1:0] BAD_TGT  = BW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        StSearch,
        StTrack,
        StLocked
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    prev_q, prev_d;
    logic [GW-1:0]   good_q, good_d;
    logic [BW-1:0]   bad_q, bad_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            err_oh_q, err_oh_d;
    logic            err_seq_q, err_seq_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [PW-1:0]   pop;
    logic [IW-1:0]   pos;
    logic            legal;
    logic [N-1:0]    exp_ring;
    logic            hit;

    always_comb begin
        pop = '0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + PW'(ring_in[i]);
            if (ring_in[i]) begin
                pos = IW'(i);
            end
        end
    end

    assign legal    = (pop == PW'(1));
    assign exp_ring = {prev_q[N-2:0], prev_q[N-1]};
    assign hit      = (ring_in == exp_ring);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        good_d    = good_q;
        bad_d     = bad_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        err_oh_d  = 1'b0;
        err_seq_d = 1'b0;

        if (en) begin
            if (legal) begin
                idx_d = pos;
            end
            unique case (state_q)
                StSearch: begin
                    if (legal) begin
                        prev_d  = ring_in;
                        good_d  = GW'(1);
                        state_d = (LOCK_CNT == 1) ? StLocked : StTrack;
                    end else begin
                        err_oh_d = 1'b1;
                    end
                end
                StTrack: begin
                    if (!legal) begin
                        err_oh_d = 1'b1;
                        good_d   = '0;
                        state_d  = StSearch;
                    end else if (hit) begin
                        prev_d = ring_in;
                        good_d = good_q + GW'(1);
                        if (good_d == LOCK_TGT) begin
                            state_d = StLocked;
                        end
                    end else begin
                        err_seq_d = 1'b1;
                        prev_d    = ring_in;
                        good_d    = GW'(1);
                    end
                end
                StLocked: begin
                    // Flywheel: keep advancing the expected position even through errors.
                    prev_d = exp_ring;
                    if (hit) begin
                        valid_d = 1'b1;
                        bad_d   = '0;
                    end else begin
                        err_oh_d  = ~legal;
                        err_seq_d = legal;
                        bad_d     = bad_q + BW'(1);
                        if (bad_d == BAD_TGT) begin
                            state_d = StSearch;
                            bad_d   = '0;
                            good_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = StSearch;
                end
            endcase
        end

        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if ((err_oh_d || err_seq_d) && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q   <= StSearch;
            prev_q    <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            err_oh_q  <= 1'b0;
            err_seq_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            err_oh_q  <= err_oh_d;
            err_seq_q <= err_seq_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign idx        = idx_q;
    assign valid      = valid_q;
    assign locked     = (state_q == StLocked);
    assign err_onehot = err_oh_q;
    assign err_seq    = err_seq_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Bench for ring_sequence_checker: directed scenarios plus random traffic, each step
// compared against a position-based reference model.
module tb_ring_sequence_checker;

    localparam int NN    = 4;
    localparam int LOCK  = 3;
    localparam int ERRL  = 2;

    logic         clk = 1'b0;
    logic         r = 1'b1;
    logic         en = 1'b0;
    logic [3:0]   ring_in = 4'b0000;
    logic         clr_err = 1'b0;
    logic [1:0]   idx;
    logic         valid;
    logic         locked;
    logic         err_onehot;
    logic         err_seq;
    logic [7:0]   err_cnt;

    int total = 0;
    int bad_cnt = 0;

    // Reference model: mode 0=search 1=track 2=locked; prev is a bit position.
    int m_mode = 0, m_prev = 0, m_good = 0, m_bad = 0, m_idx = 0, m_cnt = 0;
    bit m_valid = 0, m_oh = 0, m_seq = 0;

    ring_sequence_checker #(
        .N        (NN),
        .LOCK_CNT (LOCK),
        .ERR_LIMIT(ERRL)
    ) dut (
        .clk       (clk),
        .r         (r),
        .en        (en),
        .ring_in   (ring_in),
        .clr_err   (clr_err),
        .idx       (idx),
        .valid     (valid),
        .locked    (locked),
        .err_onehot(err_onehot),
        .err_seq   (err_seq),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model(input bit rr, input bit e, input logic [3:0] ring, input bit clr);
        int pc;
        int p;
        int ex;
        bit lg;
        m_valid = 0;
        m_oh    = 0;
        m_seq   = 0;
        if (rr) begin
            m_mode = 0; m_prev = 0; m_good = 0; m_bad = 0; m_idx = 0; m_cnt = 0;
        end else begin
            if (e) begin
                pc = $countones(ring);
                lg = (pc == 1);
                p  = 0;
                for (int i = 0; i < NN; i++) if (ring[i]) p = i;
                ex = (m_prev + 1) % NN;
                if (lg) m_idx = p;
                case (m_mode)
                    0: begin
                        if (lg) begin
                            m_prev = p; m_good = 1; m_mode = (LOCK == 1) ? 2 : 1;
                        end else m_oh = 1;
                    end
                    1: begin
                        if (!lg) begin
                            m_oh = 1; m_good = 0; m_mode = 0;
                        end else if (p == ex) begin
                            m_prev = p; m_good++;
                            if (m_good == LOCK) m_mode = 2;
                        end else begin
                            m_seq = 1; m_prev = p; m_good = 1;
                        end
                    end
                    default: begin
                        m_prev = ex;
                        if (lg && p == ex) begin
                            m_valid = 1; m_bad = 0;
                        end else begin
                            if (lg) m_seq = 1; else m_oh = 1;
                            m_bad++;
                            if (m_bad == ERRL) begin
                                m_mode = 0; m_bad = 0; m_good = 0;
                            end
                        end
                    end
                endcase
            end
            if (clr) m_cnt = 0;
            else if ((m_oh || m_seq) && m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".idx"}, 32'(idx), 32'(m_idx));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".locked"}, 32'(locked), 32'(m_mode == 2));
        chk({tag, ".err_onehot"}, 32'(err_onehot), 32'(m_oh));
        chk({tag, ".err_seq"}, 32'(err_seq), 32'(m_seq));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
    endtask

    task automatic step(input bit rr, input bit e, input logic [3:0] ring, input bit clr,
                        input string tag);
        r       = rr;
        en      = e;
        ring_in = ring;
        clr_err = clr;
        @(posedge clk);
        model(rr, e, ring, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] rv;
        int gp;
        int sel;

        // Reset state
        step(1, 0, 4'b0000, 0, "rst");
        step(1, 1, 4'b0001, 0, "rst2");
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_idx", 32'(idx), 0);

        // 1: lock on a clean rotation
        step(0, 1, 4'b0001, 0, "t1a");
        step(0, 1, 4'b0010, 0, "t1b");
        chk("t1_unlocked_b", 32'(locked), 0);
        step(0, 1, 4'b0100, 0, "t1c");
        chk("t1_locked", 32'(locked), 1);
        chk("t1_no_valid_on_lock", 32'(valid), 0);
        step(0, 1, 4'b1000, 0, "t1d");
        chk("t1_valid", 32'(valid), 1);
        chk("t1_idx", 32'(idx), 3);
        chk("t1_err_cnt", 32'(err_cnt), 0);

        // 2: flywheel through one bad sample
        step(0, 1, 4'b0110, 0, "t2a");
        chk("t2_err_onehot", 32'(err_onehot), 1);
        chk("t2_locked", 32'(locked), 1);
        chk("t2_err_cnt", 32'(err_cnt), 1);
        chk("t2_idx_hold", 32'(idx), 3);
        step(0, 1, 4'b0010, 0, "t2b");
        chk("t2_valid", 32'(valid), 1);
        chk("t2_idx", 32'(idx), 1);

        // 3: two consecutive bad samples drop lock
        step(0, 1, 4'b0000, 0, "t3a");
        chk("t3_oh1", 32'(err_onehot), 1);
        chk("t3_locked1", 32'(locked), 1);
        step(0, 1, 4'b0101, 0, "t3b");
        chk("t3_oh2", 32'(err_onehot), 1);
        chk("t3_unlocked", 32'(locked), 0);
        chk("t3_err_cnt", 32'(err_cnt), 3);
        step(0, 1, 4'b0001, 0, "t3c");
        chk("t3_restart_idx", 32'(idx), 0);

        // 4: sequence error in TRACK, then relock
        step(0, 1, 4'b0100, 0, "t4a");
        chk("t4_err_seq", 32'(err_seq), 1);
        chk("t4_unlocked", 32'(locked), 0);
        step(0, 1, 4'b1000, 0, "t4b");
        step(0, 1, 4'b0001, 0, "t4c");
        chk("t4_locked", 32'(locked), 1);
        chk("t4_err_cnt", 32'(err_cnt), 4);

        // 5: en=0 holds everything; reset wins mid-lock
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 4'b1111, 0, "t5hold");
            chk("t5_locked", 32'(locked), 1);
            chk("t5_idx", 32'(idx), 0);
            chk("t5_err_cnt", 32'(err_cnt), 4);
            chk("t5_pulses", 32'({valid, err_onehot, err_seq}), 0);
        end
        step(1, 1, 4'b0010, 0, "t5rst");
        chk("t5_rst_all", 32'({idx, valid, locked, err_onehot, err_seq, err_cnt}), 0);

        // 6: saturation and clear priority
        for (int i = 0; i < 300; i++) step(0, 1, 4'b0000, 0, "t6sat");
        chk("t6_sat", 32'(err_cnt), 255);
        step(0, 1, 4'b0011, 1, "t6clr");
        chk("t6_clr", 32'(err_cnt), 0);
        chk("t6_clr_pulse", 32'(err_onehot), 1);

        // Random traffic, mostly well-formed rotation with injected faults
        gp = 0;
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 75) begin
                rv = 4'(1 << gp);
                gp = (gp + 1) % NN;
            end else if (sel < 88) begin
                rv = 4'($urandom_range(0, 15));
            end else begin
                rv = 4'(1 << $urandom_range(0, 3));
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), rv,
                 ($urandom_range(0, 39) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
